// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a per-register pending (scoreboard) bit.
// Register 0 reads as zero; optional same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NRD*ADDR_W-1:0]  ra,
    output logic [NRD*DATA_W-1:0]  rd,
    output logic [NRD-1:0]         rdy,
    input  logic                   we_a,
    input  logic [ADDR_W-1:0]      wa_a,
    input  logic [DATA_W-1:0]      wd_a,
    input  logic                   we_b,
    input  logic [ADDR_W-1:0]      wa_b,
    input  logic [DATA_W-1:0]      wd_b,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic [ADDR_W:0]        pend_cnt
);
    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] rf_data [NREG];
    logic [NREG-1:0]   pend_vec;
    logic [NREG-1:0]   pend_next;
    logic [ADDR_W:0]   pend_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf_data[gi]   = '0;
                assign pend_vec[gi]  = 1'b0;
                assign pend_next[gi] = 1'b0;
            end else begin : g_live
                logic              hit_a;
                logic              hit_b;
                logic              hit_r;
                logic [DATA_W-1:0] data_reg;
                logic              pend_reg;

                assign hit_a = we_a   && (wa_a     == ADDR_W'(gi));
                assign hit_b = we_b   && (wa_b     == ADDR_W'(gi));
                assign hit_r = rsv_en && (rsv_addr == ADDR_W'(gi));

                // A reserve in the same cycle as a write leaves the register pending.
                assign pend_next[gi] = hit_r ? 1'b1 : ((hit_a || hit_b) ? 1'b0 : pend_reg);

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        data_reg <= '0;
                        pend_reg <= 1'b0;
                    end else begin
                        if (hit_b) begin
                            data_reg <= wd_b;
                        end else if (hit_a) begin
                            data_reg <= wd_a;
                        end
                        pend_reg <= pend_next[gi];
                    end
                end

                assign rf_data[gi]  = data_reg;
                assign pend_vec[gi] = pend_reg;
            end
        end
    endgenerate

    always_comb begin
        pend_cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_cnt_next = pend_cnt_next + (ADDR_W+1)'(pend_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cnt <= '0;
        end else begin
            pend_cnt <= pend_cnt_next;
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;
            logic              ok;

            assign addr = ra[gi*ADDR_W +: ADDR_W];

            // Forwarding is suppressed during reset so reads stay at zero.
            always_comb begin
                data = rf_data[addr];
                ok   = ~pend_vec[addr];
                if (BYPASS != 0 && !reset && addr != '0) begin
                    if (we_b && wa_b == addr) begin
                        data = wd_b;
                        ok   = 1'b1;
                    end else if (we_a && wa_a == addr) begin
                        data = wd_a;
                        ok   = 1'b1;
                    end
                end
            end

            assign rd[gi*DATA_W +: DATA_W] = data;
            assign rdy[gi]                 = ok;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: table of vectors on a forwarding instance,
// plus hand sequences for async reset and the non-forwarding variant.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  ra;
    logic [63:0] rd, rd_nb;
    logic [1:0]  rdy, rdy_nb;
    logic        we_a, we_b, rsv_en;
    logic [4:0]  wa_a, wa_b, rsv_addr;
    logic [31:0] wd_a, wd_b;
    logic [5:0]  pend_cnt, pend_cnt_nb;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1)) u_dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rdy(rdy),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .rdy(rdy_nb),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt_nb)
    );

    typedef struct {
        logic        we_a;
        logic [4:0]  wa_a;
        logic [31:0] wd_a;
        logic        we_b;
        logic [4:0]  wa_b;
        logic [31:0] wd_b;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic [4:0]  ra0, ra1;
        logic [31:0] rd0, rd1;
        logic [1:0]  rdy;
        logic [5:0]  pc;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(
        input logic wea, input logic [4:0] waa, input logic [31:0] wda,
        input logic web, input logic [4:0] wab, input logic [31:0] wdb,
        input logic rse, input logic [4:0] rsa,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic [1:0] ry, input logic [5:0] pc);
        vec_t v;
        v.we_a = wea; v.wa_a = waa; v.wd_a = wda;
        v.we_b = web; v.wa_b = wab; v.wd_b = wdb;
        v.rsv_en = rse; v.rsv_addr = rsa;
        v.ra0 = r0; v.ra1 = r1; v.rd0 = d0; v.rd1 = d1;
        v.rdy = ry; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we_a = 1'b0; wa_a = 5'd0; wd_a = 32'd0;
        we_b = 1'b0; wa_b = 5'd0; wd_b = 32'd0;
        rsv_en = 1'b0; rsv_addr = 5'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b11, 6'd0);
        vecs[1]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 6'd0);
        vecs[2]  = mk(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 2'b11, 6'd0);
        vecs[3]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h22, 32'h0, 2'b11, 6'd0);
        vecs[4]  = mk(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h0, 32'h22, 2'b11, 6'd0);
        vecs[5]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3, 32'h0, 32'h0, 2'b11, 6'd0);
        vecs[6]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4, 32'h0, 32'h0, 2'b10, 6'd1);
        vecs[7]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4, 32'h0, 32'h0, 2'b00, 6'd2);
        vecs[8]  = mk(1'b1, 5'd3, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4, 32'h5, 32'h0, 2'b01, 6'd2);
        vecs[9]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4, 32'h5, 32'h0, 2'b01, 6'd1);
        vecs[10] = mk(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 5'd9, 5'd4, 32'hA, 32'h44, 2'b11, 6'd1);
        vecs[11] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd4, 32'hA, 32'h44, 2'b10, 6'd1);
        vecs[12] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd2, 32'hA, 32'h0, 2'b10, 6'd1);
        vecs[13] = mk(1'b1, 5'd2, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2, 5'd9, 32'h1234, 32'hA, 2'b01, 6'd1);
        vecs[14] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd0, 32'h1234, 32'h0, 2'b10, 6'd2);

        // Reset state, with a write request that must be ignored
        reset = 1'b1;
        idle();
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h99;
        ra = {5'd0, 5'd5};
        #2;
        chk("reset_rd0", rd[31:0], 32'h0);
        chk("reset_rdy", {30'd0, rdy}, {30'd0, 2'b11});
        chk("reset_pc", {26'd0, pend_cnt}, 32'd0);
        #10;
        idle();
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            we_a = vecs[i].we_a; wa_a = vecs[i].wa_a; wd_a = vecs[i].wd_a;
            we_b = vecs[i].we_b; wa_b = vecs[i].wa_b; wd_b = vecs[i].wd_b;
            rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
            ra = {vecs[i].ra1, vecs[i].ra0};
            #1;
            $display("vec %0d: ra=%0d/%0d rd=%h/%h rdy=%b pc=%0d", i, vecs[i].ra0, vecs[i].ra1,
                     rd[31:0], rd[63:32], rdy, pend_cnt);
            chk($sformatf("v%0d_rd0", i), rd[31:0], vecs[i].rd0);
            chk($sformatf("v%0d_rd1", i), rd[63:32], vecs[i].rd1);
            chk($sformatf("v%0d_rdy", i), {30'd0, rdy}, {30'd0, vecs[i].rdy});
            chk($sformatf("v%0d_pc", i), {26'd0, pend_cnt}, {26'd0, vecs[i].pc});
            chk($sformatf("v%0d_pc_nb", i), {26'd0, pend_cnt_nb}, {26'd0, vecs[i].pc});
            @(posedge clk);
            #1;
        end

        // Async reset mid-cycle with r2 and r9 pending and a write in flight
        idle();
        we_a = 1'b1; wa_a = 5'd6; wd_a = 32'h66;
        ra = {5'd6, 5'd2};
        #1;
        chk("pre_rst_pc", {26'd0, pend_cnt}, 32'd2);
        #1;
        reset = 1'b1;
        #1;
        $display("async reset: rd=%h/%h rdy=%b pc=%0d", rd[31:0], rd[63:32], rdy, pend_cnt);
        chk("arst_rd0", rd[31:0], 32'h0);
        chk("arst_rd1", rd[63:32], 32'h0);
        chk("arst_rdy", {30'd0, rdy}, {30'd0, 2'b11});
        chk("arst_pc", {26'd0, pend_cnt}, 32'd0);
        chk("arst_rd0_nb", rd_nb[31:0], 32'h0);
        chk("arst_pc_nb", {26'd0, pend_cnt_nb}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        ra = {5'd6, 5'd9};
        #1;
        $display("post reset: rd=%h/%h rdy=%b pc=%0d", rd[31:0], rd[63:32], rdy, pend_cnt);
        chk("post_rst_r9", rd[31:0], 32'h0);
        chk("post_rst_r6", rd[63:32], 32'h0);
        chk("post_rst_rdy", {30'd0, rdy}, {30'd0, 2'b11});

        // First edge after deassertion performs a normal write
        we_a = 1'b1; wa_a = 5'd1; wd_a = 32'h77;
        @(posedge clk);
        #1;
        idle();
        ra = {5'd0, 5'd1};
        #1;
        $display("first write after reset: rd=%h rd_nb=%h", rd[31:0], rd_nb[31:0]);
        chk("first_wr", rd[31:0], 32'h77);
        chk("first_wr_nb", rd_nb[31:0], 32'h77);

        // Non-forwarding instance: new data and rdy visible only after the edge
        we_b = 1'b1; wa_b = 5'd12; wd_b = 32'h55;
        ra = {5'd0, 5'd12};
        #1;
        $display("write r12: rd=%h rd_nb=%h", rd[31:0], rd_nb[31:0]);
        chk("fwd_r12", rd[31:0], 32'h55);
        chk("nofwd_r12_pre", rd_nb[31:0], 32'h0);
        @(posedge clk);
        #1;
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd12;
        #1;
        chk("nofwd_r12_post", rd_nb[31:0], 32'h55);
        chk("nofwd_rsv_same", {31'd0, rdy_nb[0]}, 32'd1);
        @(posedge clk);
        #1;
        idle();
        we_a = 1'b1; wa_a = 5'd12; wd_a = 32'h56;
        #1;
        $display("write pending r12: rdy=%b rdy_nb=%b pc_nb=%0d", rdy, rdy_nb, pend_cnt_nb);
        chk("nofwd_pend_rdy", {31'd0, rdy_nb[0]}, 32'd0);
        chk("nofwd_pend_pc", {26'd0, pend_cnt_nb}, 32'd1);
        chk("fwd_pend_rdy", {31'd0, rdy[0]}, 32'd1);
        chk("nofwd_pend_rd", rd_nb[31:0], 32'h55);
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("nofwd_clr_rdy", {31'd0, rdy_nb[0]}, 32'd1);
        chk("nofwd_clr_rd", rd_nb[31:0], 32'h56);
        chk("nofwd_clr_pc", {26'd0, pend_cnt_nb}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count NREG = 2**ADDR_W.
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ra  input  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-008 rd  output  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-009 rdy  output  NRD  port k data valid (register not pending).
REQ-010 we_a, wa_a, wd_a  input  1/ADDR_W/DATA_W  write port A enable, address, data.
REQ-011 we_b, wa_b, wd_b  input  1/ADDR_W/DATA_W  write port B enable, address, data.
REQ-012 rsv_en, rsv_addr  input  1/ADDR_W  reserve request: mark register pending.
REQ-013 pend_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-014 Storage: NREG registers of DATA_W bits plus one pending bit per register.
REQ-015 Register 0 hardwired: reads 0, rdy=1; writes and reserves to address 0 ignored.
REQ-016 Write: we_x=1 and wa_x!=0 -> register wa_x takes wd_x at next edge, its pending bit cleared.
REQ-017 Dual write same address (we_a=we_b=1, wa_a==wa_b): port B data stored; A discarded.
REQ-018 Reserve: rsv_en=1, rsv_addr!=0 -> pending bit set at next edge; register data unchanged.
REQ-019 Reserve and write same address same cycle: data written, pending ends SET (reserve wins).
REQ-020 Reserve of already-pending register: stays pending; no error, pend_cnt unchanged.
REQ-021 Read combinational: rd[k] = register ra[k]; rdy[k] = NOT pending[ra[k]].
REQ-022 BYPASS=1: ra[k] matches an enabled same-cycle write (nonzero) -> rd[k]=write data (B over A), rdy[k]=1.
REQ-023 BYPASS=0: reads return pre-edge contents and pending state; new data visible cycle after write.
REQ-024 Same-cycle reserve does not affect rdy until after the edge (both BYPASS modes).
REQ-025 pend_cnt registered, equals population count of pending bits after each edge; max NREG-1.
REQ-026 All read ports independent; any ports may address same register.

Reset
REQ-027 reset=1 asynchronously clears all registers to 0, all pending bits to 0, pend_cnt to 0.
REQ-028 While reset=1 writes and reserves ignored; rd reads 0, rdy all 1.
REQ-029 Deassertion: first rising edge with reset=0 performs normal update.
REQ-030 Reset mid-operation (pending bits set, writes in flight) -> all state cleared, no partial write retained.

Verification
REQ-031 Reset then write r5=0xDEADBEEF via A; next cycle ra[0]=5 -> rd=0xDEADBEEF, rdy[0]=1.
REQ-032 we_a=we_b=1 to r7, wd_a=0x11, wd_b=0x22 -> r7=0x22; BYPASS=1 same-cycle read of r7 gives 0x22.
REQ-033 Write 0xFFFFFFFF to r0, reserve r0 -> ra=0 reads 0, rdy=1, pend_cnt=0.
REQ-034 Reserve r3, r4 -> pend_cnt=2, rdy low on r3/r4; write r3=0x5 -> pend_cnt=1, r3 rdy=1.
REQ-035 Reserve r9 and write r9=0xA same cycle -> r9=0xA, still pending, pend_cnt=1.
REQ-036 Assert reset asynchronously between edges with r2=0x1234 pending -> rd=0, rdy=1, pend_cnt=0 immediately.
